fixed_point_complex_multiplier: RTL and testbench
=================================================

Name: fixed_point_complex_multiplier

Overview:
Pipelined, parametrised, saturating complex fixed-point multiplier: P = A × B (or A × conj(B)), signed two's-complement, with per-operand Q formats.
- Next-generation multiplier for the spectrogram/FFT datapath; the butterfly and windowing stages instantiate it.
- Adds generic widths, valid/ready streaming with backpressure, rounding, and per-sample plus sticky overflow reporting.

Parameters:
DATA_WIDTH, 16, width of every real/imag operand and result component
FRAC_A, 15, fraction bits of A
FRAC_B, 15, fraction bits of B (twiddle, Q1.15)
FRAC_P, 15, fraction bits of P; SHIFT = FRAC_A+FRAC_B-FRAC_P must be >= 0 (elaboration error otherwise)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
conj_b  in  1  1: multiply by conj(B); sampled with the inputs
a_re, a_im  in  DATA_WIDTH each  operand A (signed)
b_re, b_im  in  DATA_WIDTH each  operand B (signed)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
p_re, p_im  out  DATA_WIDTH each  result (signed)
sat  out  2  per-result clamp flags {im,re}, aligned with p_*
sat_sticky  out  1  set when any delivered result saturates; cleared only by rst

Behaviour:
- Pipeline stages:
  - S1 registers the operands and conj_b. When conj_b=1, b_im is negated at full width DATA_WIDTH+1, so -(-2^(W-1)) is exact.
  - S2 registers the four 2W+1-bit partial products.
  - S3 (output register) forms re = ar·br − ai·bi and im = ar·bi + ai·br at 2W+2 bits, rounds or truncates, then saturates.
- Latency: exactly 3 cycles from accept (in_valid & in_ready) to out_valid when unstalled. Throughput is 1 sample/cycle.
- Stall:
  - adv = !out_valid | out_ready; in_ready = adv (combinational).
  - When adv=0, all stages, including bubbles, hold.
  - Maximum 3 samples in flight.
  - Data and valid are stable while out_valid & !out_ready.
- Scaling: arithmetic shift right by SHIFT. Rounding follows the Optional Feature.
- Saturation:
  - If the shifted value exceeds DATA_WIDTH signed range, clamp to +2^(W-1)−1 or −2^(W-1) and set that component's sat bit.
  - No special zero-operand path is needed; zero yields 0 naturally.
- sat_sticky sets on the cycle a result with any sat bit is transferred (out_valid & out_ready).
- Reset: on the rst edge, all valids are 0, p_re, p_im and sat are 0, and sat_sticky is 0. in_ready=1 on the first cycle after reset.
  - Samples in flight are discarded.
  - A sample presented in the same cycle as rst is not accepted.
- Simultaneous accept and output transfer in one cycle is allowed; occupancy is unchanged.

Optional Feature:
- Macro FXMUL_ROUND_EN.
- Defined: round half up, i.e. add 2^(SHIFT−1) before the shift. The add happens before saturation, so a rounding carry can trigger saturation. No-op when SHIFT=0.
- Undefined: truncation (floor toward −∞).
- Latency is identical in both builds.

Decomposition:
- Package fxmul_pkg holds:
  - localparam helpers: SHIFT, PROD_W = 2·DATA_WIDTH+1, SUM_W = 2·DATA_WIDTH+2;
  - max/min saturation constants;
  - function sat_round(value, shift) returning {flag, result}.
- One sub-module, fixed_point_round_sat (combinational, SUM_W→DATA_WIDTH), instantiated twice (re, im) feeding S3.

Test Plan:
1. Defaults, a=(16384,0), b=(16384,16384), conj_b=0, out_ready=1 -> 3 cycles later p=(8192,8192), sat=00.
2. a=(-32768,0), b=(-32768,0) -> p_re=32767, p_im=0, sat=01, sat_sticky=1 after transfer. a=(32767,32767), b=(32767,-32767) -> p=(32767,0), sat=01.
3. a=(1,0), b=(16384,0): FXMUL_ROUND_EN -> p_re=1; undefined -> p_re=0. a=(-1,0), same b: ROUND_EN -> 0; undefined -> -1.
4. a=(0,16384), b=(0,16384): conj_b=0 -> p=(-8192,0); conj_b=1 -> p=(8192,0).
5. Hold out_ready=0 and stream 5 samples -> exactly 3 accepted, in_ready=0 with p stable. Release -> 5 results in order, back-to-back, none lost or duplicated.
6. Assert rst for 1 cycle with 2 samples in flight -> no out_valid for those samples, sat_sticky=0, in_ready=1 on the next cycle, and a new sample emerges 3 cycles after accept.

Source files
------------

// File: rtl/fxmul_pkg.sv
// Shared helpers for the complex multiplier: width arithmetic, saturation limits
// and the round/shift/clamp function. FXMUL_ROUND_EN selects round-half-up over truncation.
package fxmul_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_A     = 15;
  localparam int DEF_FRAC_B     = 15;
  localparam int DEF_FRAC_P     = 15;

  // All rounding and clamping is evaluated in a 64-bit signed workspace.
  // This caps DATA_WIDTH so that SUM_W plus a rounding carry still fits.
  localparam int CALC_W         = 64;
  localparam int MAX_DATA_WIDTH = 30;

  function automatic int shift_of(input int frac_a, input int frac_b, input int frac_p);
    return frac_a + frac_b - frac_p;
  endfunction

  function automatic int prod_w(input int data_width);
    return 2 * data_width + 1;
  endfunction

  function automatic int sum_w(input int data_width);
    return 2 * data_width + 2;
  endfunction

  function automatic logic signed [CALC_W-1:0] sat_max(input int data_width);
    return (64'sd1 <<< (data_width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [CALC_W-1:0] sat_min(input int data_width);
    return -(64'sd1 <<< (data_width - 1));
  endfunction

  // Returns {flag, result}. Only the low data_width bits of result are meaningful.
  function automatic logic [MAX_DATA_WIDTH:0] sat_round(input logic signed [CALC_W-1:0] value,
                                                        input int shift,
                                                        input int data_width);
    logic signed [CALC_W-1:0] v;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    logic                     flag;
    logic [MAX_DATA_WIDTH-1:0] res;
    v = value;
`ifdef FXMUL_ROUND_EN
    // Rounding bias is added before clamping, so a carry can push into saturation.
    if (shift > 0) v = v + (64'sd1 <<< (shift - 1));
`endif
    v    = v >>> shift;
    hi   = sat_max(data_width);
    lo   = sat_min(data_width);
    flag = 1'b0;
    res  = v[MAX_DATA_WIDTH-1:0];
    if (v > hi) begin
      flag = 1'b1;
      res  = hi[MAX_DATA_WIDTH-1:0];
    end else if (v < lo) begin
      flag = 1'b1;
      res  = lo[MAX_DATA_WIDTH-1:0];
    end
    return {flag, res};
  endfunction

endpackage

// File: rtl/fixed_point_complex_multiplier_round_sat.sv
// Combinational SUM_W -> DATA_WIDTH scaler: arithmetic shift by SHIFT, optional
// round-half-up (FXMUL_ROUND_EN), then clamp to the signed DATA_WIDTH range.
module fixed_point_round_sat
  import fxmul_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SUM_W      = 2 * DEF_DATA_WIDTH + 2,
  parameter int SHIFT      = DEF_FRAC_A + DEF_FRAC_B - DEF_FRAC_P
) (
  input  logic signed [SUM_W-1:0]      value,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         sat
);

  logic signed [CALC_W-1:0]   value_ext;
  // Upper result bits beyond DATA_WIDTH are don't-care and intentionally dropped.
  logic [MAX_DATA_WIDTH:0]    rs_word_unused;

  assign value_ext      = CALC_W'(value);
  assign rs_word_unused = sat_round(value_ext, SHIFT, DATA_WIDTH);
  assign sat            = rs_word_unused[MAX_DATA_WIDTH];
  assign result         = rs_word_unused[DATA_WIDTH-1:0];

endmodule

// File: rtl/fixed_point_complex_multiplier.sv
// Three-stage saturating complex multiplier P = A*B or A*conj(B) with valid/ready
// streaming. Build with FXMUL_ROUND_EN for round-half-up, otherwise truncation.
module fixed_point_complex_multiplier
  import fxmul_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_A     = DEF_FRAC_A,
  parameter int FRAC_B     = DEF_FRAC_B,
  parameter int FRAC_P     = DEF_FRAC_P
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  conj_b,
  input  logic [DATA_WIDTH-1:0] a_re,
  input  logic [DATA_WIDTH-1:0] a_im,
  input  logic [DATA_WIDTH-1:0] b_re,
  input  logic [DATA_WIDTH-1:0] b_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] p_re,
  output logic [DATA_WIDTH-1:0] p_im,
  output logic [1:0]            sat,
  output logic                  sat_sticky
);

  localparam int SHIFT  = shift_of(FRAC_A, FRAC_B, FRAC_P);
  localparam int PROD_W = prod_w(DATA_WIDTH);
  localparam int SUM_W  = sum_w(DATA_WIDTH);
  localparam int BI_W   = DATA_WIDTH + 1;

  if (SHIFT < 0) begin : g_bad_shift
    $error("FRAC_A + FRAC_B - FRAC_P must be >= 0");
  end
  if (DATA_WIDTH < 2 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH out of supported range");
  end

  // Handshake: a sample is accepted when in_valid & in_ready, a result is delivered
  // when out_valid & out_ready. The whole pipe advances only when the output slot is
  // free or being drained (adv); otherwise every stage, bubbles included, holds.
  logic adv;

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [DATA_WIDTH-1:0] ar1_q, ar1_d, ai1_q, ai1_d, br1_q, br1_d;
  logic signed [BI_W-1:0]       bi1_q, bi1_d, bi_ext;
  logic signed [PROD_W-1:0]     rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
  logic signed [SUM_W-1:0]      re_sum, im_sum;
  logic signed [DATA_WIDTH-1:0] re_rs, im_rs;
  logic                         re_flag, im_flag;
  logic signed [DATA_WIDTH-1:0] p_re_q, p_re_d, p_im_q, p_im_d;
  logic [1:0]                   sat_q, sat_d;
  logic                         sat_sticky_q, sat_sticky_d;

  // Widened first so negating the most negative b_im is exact.
  assign bi_ext = BI_W'($signed(b_im));

  assign re_sum = SUM_W'(rr_q) - SUM_W'(ii_q);
  assign im_sum = SUM_W'(ri_q) + SUM_W'(ir_q);

  fixed_point_round_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .SUM_W      (SUM_W),
    .SHIFT      (SHIFT)
  ) u_rs_re (
    .value  (re_sum),
    .result (re_rs),
    .sat    (re_flag)
  );

  fixed_point_round_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .SUM_W      (SUM_W),
    .SHIFT      (SHIFT)
  ) u_rs_im (
    .value  (im_sum),
    .result (im_rs),
    .sat    (im_flag)
  );

  always_comb begin
    adv    = !v3_q || out_ready;
    v1_d   = v1_q;
    ar1_d  = ar1_q;
    ai1_d  = ai1_q;
    br1_d  = br1_q;
    bi1_d  = bi1_q;
    v2_d   = v2_q;
    rr_d   = rr_q;
    ii_d   = ii_q;
    ri_d   = ri_q;
    ir_d   = ir_q;
    v3_d   = v3_q;
    p_re_d = p_re_q;
    p_im_d = p_im_q;
    sat_d  = sat_q;
    if (adv) begin
      v1_d   = in_valid;
      ar1_d  = a_re;
      ai1_d  = a_im;
      br1_d  = b_re;
      bi1_d  = conj_b ? -bi_ext : bi_ext;
      v2_d   = v1_q;
      rr_d   = PROD_W'(ar1_q) * PROD_W'(br1_q);
      ii_d   = PROD_W'(ai1_q) * PROD_W'(bi1_q);
      ri_d   = PROD_W'(ar1_q) * PROD_W'(bi1_q);
      ir_d   = PROD_W'(ai1_q) * PROD_W'(br1_q);
      v3_d   = v2_q;
      p_re_d = re_rs;
      p_im_d = im_rs;
      sat_d  = {im_flag, re_flag};
    end
    sat_sticky_d = sat_sticky_q || (v3_q && out_ready && (sat_q != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q         <= 1'b0;
      ar1_q        <= '0;
      ai1_q        <= '0;
      br1_q        <= '0;
      bi1_q        <= '0;
      v2_q         <= 1'b0;
      rr_q         <= '0;
      ii_q         <= '0;
      ri_q         <= '0;
      ir_q         <= '0;
      v3_q         <= 1'b0;
      p_re_q       <= '0;
      p_im_q       <= '0;
      sat_q        <= 2'b00;
      sat_sticky_q <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      ar1_q        <= ar1_d;
      ai1_q        <= ai1_d;
      br1_q        <= br1_d;
      bi1_q        <= bi1_d;
      v2_q         <= v2_d;
      rr_q         <= rr_d;
      ii_q         <= ii_d;
      ri_q         <= ri_d;
      ir_q         <= ir_d;
      v3_q         <= v3_d;
      p_re_q       <= p_re_d;
      p_im_q       <= p_im_d;
      sat_q        <= sat_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign in_ready   = adv;
  assign out_valid  = v3_q;
  assign p_re       = p_re_q;
  assign p_im       = p_im_q;
  assign sat        = sat_q;
  assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_fixed_point_complex_multiplier.sv
// Bench for fixed_point_complex_multiplier: directed checks plus randomized streaming
// against an integer reference model and an expected-result queue.
module tb_fixed_point_complex_multiplier;

  localparam int W     = 16;
  localparam int SHIFT = 15;
  localparam int EW    = 2 * W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         conj_b = 1'b0;
  logic [W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] p_re, p_im;
  logic [1:0]   sat;
  logic         sat_sticky;

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer = 0;
  logic [EW-1:0] exp_q[$];
  logic          model_sticky = 1'b0;

  fixed_point_complex_multiplier dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .conj_b     (conj_b),
    .a_re       (a_re),
    .a_im       (a_im),
    .b_re       (b_re),
    .b_im       (b_im),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p_re       (p_re),
    .p_im       (p_im),
    .sat        (sat),
    .sat_sticky (sat_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scale one component: optional half-up bias, floor division by 2^SHIFT, clamp.
  function automatic logic [W:0] scale(input longint v);
    longint den;
    longint q;
    logic   s;
    logic [W-1:0] r;
    den = longint'(1) << SHIFT;
`ifdef FXMUL_ROUND_EN
    v = v + den / 2;
`endif
    q = v / den;
    if ((v % den != 0) && (v < 0)) q = q - 1;
    s = 1'b0;
    if (q > 32767) begin
      q = 32767;
      s = 1'b1;
    end else if (q < -32768) begin
      q = -32768;
      s = 1'b1;
    end
    r = q[W-1:0];
    return {s, r};
  endfunction

  function automatic logic [EW-1:0] model(input logic [W-1:0] ar, ai, br, bi, input logic cj);
    longint xr, xi, yr, yi, re, im;
    logic [W:0] sr, si;
    xr = $signed(ar);
    xi = $signed(ai);
    yr = $signed(br);
    yi = $signed(bi);
    if (cj) yi = -yi;
    re = xr * yr - xi * yi;
    im = xr * yi + xi * yr;
    sr = scale(re);
    si = scale(im);
    return {si[W], sr[W], si[W-1:0], sr[W-1:0]};
  endfunction

  // Scoreboard: push on accept, pop and compare on delivery.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      exp_q.delete();
      model_sticky = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_p_re", $signed(p_re), $signed(e[W-1:0]));
          check("sb_p_im", $signed(p_im), $signed(e[2*W-1:W]));
          check("sb_sat", sat, e[EW-1:2*W]);
          check("sb_sticky", sat_sticky, model_sticky);
          if (e[EW-1:2*W] != 2'b00) model_sticky = 1'b1;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a_re, a_im, b_re, b_im, conj_b));
    end
  end

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      2:       return 16'h0000;
      3:       return 16'hffff;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic set_random_inputs();
    a_re   = rand_val();
    a_im   = rand_val();
    b_re   = rand_val();
    b_im   = rand_val();
    conj_b = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] ar, ai, br, bi, input logic cj);
    int waited;
    @(posedge clk); #1;
    a_re = ar; a_im = ai; b_re = br; b_im = bi; conj_b = cj;
    in_valid = 1'b1;
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Requires an empty pipe and out_ready=1; checks exact 3-cycle latency and the result.
  task automatic send_check(input string tag, input logic [W-1:0] ar, ai, br, bi,
                            input logic cj, input int er, input int ei, input int es);
    send(ar, ai, br, bi, cj);
    @(negedge clk); check({tag, "_lat1"}, out_valid, 0);
    @(negedge clk); check({tag, "_lat2"}, out_valid, 0);
    @(negedge clk); check({tag, "_lat3"}, out_valid, 1);
    check({tag, "_re"}, $signed(p_re), er);
    check({tag, "_im"}, $signed(p_im), ei);
    check({tag, "_sat"}, sat, es);
  endtask

  initial begin
    int k;
    int base;
    logic [W-1:0] held_re, held_im;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_p_re", p_re, 0);
    check("rst_p_im", p_im, 0);
    check("rst_sat", sat, 0);
    check("rst_sticky", sat_sticky, 0);
    check("rst_in_ready", in_ready, 1);

    // Basic product and saturation
    send_check("t1", 16'd16384, 16'd0, 16'd16384, 16'd16384, 1'b0, 8192, 8192, 0);
    send_check("t2a", 16'h8000, 16'd0, 16'h8000, 16'd0, 1'b0, 32767, 0, 1);
    @(posedge clk); #1;
    @(negedge clk); check("t2_sticky", sat_sticky, 1);
    send_check("t2b", 16'd32767, 16'd32767, 16'd32767, -16'sd32767, 1'b0, 32767, 0, 1);

    // Rounding vs truncation
`ifdef FXMUL_ROUND_EN
    send_check("t3a", 16'd1, 16'd0, 16'd16384, 16'd0, 1'b0, 1, 0, 0);
    send_check("t3b", 16'hffff, 16'd0, 16'd16384, 16'd0, 1'b0, 0, 0, 0);
`else
    send_check("t3a", 16'd1, 16'd0, 16'd16384, 16'd0, 1'b0, 0, 0, 0);
    send_check("t3b", 16'hffff, 16'd0, 16'd16384, 16'd0, 1'b0, -1, 0, 0);
`endif

    // Conjugate
    send_check("t4a", 16'd0, 16'd16384, 16'd0, 16'd16384, 1'b0, -8192, 0, 0);
    send_check("t4b", 16'd0, 16'd16384, 16'd0, 16'd16384, 1'b1, 8192, 0, 0);

    // Backpressure: 5 offered, 3 accepted, output held stable
    @(posedge clk); #1;
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      set_random_inputs();
      in_valid = (k < 5);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
    end
    check("t5_accepted", k, 3);
    @(negedge clk);
    check("t5_in_ready", in_ready, 0);
    check("t5_out_valid", out_valid, 1);
    held_re = p_re;
    held_im = p_im;
    check("t5_head_re", $signed(p_re), $signed(exp_q[0][W-1:0]));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_hold_re", p_re, held_re);
      check("t5_hold_im", p_im, held_im);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    base = n_xfer;
    for (int c = 0; c < 5; c++) begin
      in_valid = (k < 5);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
      set_random_inputs();
    end
    in_valid = 1'b0;
    check("t5_b2b_xfers", n_xfer - base, 5);
    check("t5_all_sent", k, 5);
    @(negedge clk);
    check("t5_drained", exp_q.size(), 0);

    // Reset with two in flight, plus a sample offered during reset
    @(posedge clk); #1;
    set_random_inputs();
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_random_inputs();
    @(posedge clk); #1;
    set_random_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_in_ready", in_ready, 1);
    check("t6_sticky", sat_sticky, 0);
    for (int c = 0; c < 4; c++) begin
      check("t6_no_out", out_valid, 0);
      @(negedge clk);
    end
    send_check("t6_new", 16'd16384, 16'd0, 16'd16384, 16'd16384, 1'b0, 8192, 8192, 0);

    // Randomized streaming with random backpressure
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      set_random_inputs();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("final_drained", exp_q.size(), 0);
    check("final_out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
